// File: rtl/camera_clkgen.sv
// camera_clkgen -- multi-channel phase-accumulator clock-enable generator for
// the ISP camera/sensor domain. A PLL lock supervisor keeps every channel idle
// until lock has been stable for SETTLE_CYC cycles. Increments are retuned
// through a valid/ready port and only change on a period boundary.
// Optional build macro: CLKGEN_SYNC_EN adds the `sync` phase-align input.
module camera_clkgen #(
  parameter int               NUM_CH     = 2,
  parameter int               ACC_W      = 24,
  parameter logic [ACC_W-1:0] INIT_INC   = 24'h0A3D71,
  parameter int               SETTLE_CYC = 1024
) (
  input  logic                                           clkin,
  input  logic                                           rst_n,
  input  logic                                           pll_lock,
  input  logic [NUM_CH-1:0]                              ch_en,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                               cfg_inc,
`ifdef CLKGEN_SYNC_EN
  input  logic                                           sync,
`endif
  output logic [NUM_CH-1:0]                              tick,
  output logic [NUM_CH-1:0]                              clk_out,
  output logic                                           locked,
  output logic [7:0]                                     relock_cnt
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t             state_r, state_nxt;
  logic [CNT_W-1:0]   settle_r, settle_nxt;
  logic [7:0]         relock_r, relock_nxt;
  logic               locked_r;

  logic [ACC_W-1:0]   acc_r [NUM_CH];
  logic [ACC_W-1:0]   inc_r [NUM_CH];
  logic [NUM_CH-1:0]  tick_r;
  logic [NUM_CH-1:0]  clk_out_r;

  logic               pend_r;
  logic [CH_W-1:0]    pend_ch_r;
  logic [ACC_W-1:0]   pend_inc_r;
  logic               cfg_ready_r;

  logic               sync_s;
  logic               sync_hit_s;
  logic               run_adv_s;
  logic [ACC_W:0]     sum_s [NUM_CH];
  logic [NUM_CH-1:0]  apply_s;
  logic               apply_any_s;

`ifdef CLKGEN_SYNC_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  // Sync only acts while running; a lock drop or sync stops every accumulator.
  assign sync_hit_s = (state_r == RUN) && sync_s;
  assign run_adv_s  = (state_r == RUN) && pll_lock && !sync_hit_s;

  // Lock supervisor next-state: settle timing and lock-loss counting.
  always_comb begin
    state_nxt  = state_r;
    settle_nxt = settle_r;
    relock_nxt = relock_r;
    case (state_r)
      WAIT_LOCK: begin
        if (pll_lock) begin
          state_nxt  = SETTLE;
          settle_nxt = {CNT_W{1'b0}};
        end else begin
          state_nxt  = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!pll_lock) begin
          state_nxt  = WAIT_LOCK;
        end else if (settle_r == SETTLE_LAST) begin
          state_nxt  = RUN;
        end else begin
          settle_nxt = settle_r + CNT_W'(1'b1);
        end
      end
      RUN: begin
        if (!pll_lock) begin
          state_nxt = WAIT_LOCK;
          if (relock_r != 8'hFF) begin
            relock_nxt = relock_r + 8'd1;
          end else begin
            relock_nxt = relock_r;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

  // Lock supervisor registers; locked mirrors the state being entered.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_r  <= WAIT_LOCK;
      settle_r <= {CNT_W{1'b0}};
      relock_r <= 8'd0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      settle_r <= settle_nxt;
      relock_r <= relock_nxt;
      locked_r <= (state_nxt == RUN);
    end
  end

  // Per-channel sums and the decision of when the pending increment may land:
  // on the carrying edge of an advancing channel, or at once if it is idle.
  always_comb begin
    logic [ACC_W:0] sum_v;
    logic           adv_v;
    logic           ch_ok_v;
    logic           any_v;
    ch_ok_v = 1'b0;
    any_v   = 1'b0;
    apply_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sum_v      = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
      sum_s[i]   = sum_v;
      adv_v      = run_adv_s && ch_en[i] && (inc_r[i] != {ACC_W{1'b0}});
      apply_s[i] = pend_r && (pend_ch_r == CH_W'(i)) && (sum_v[ACC_W] || !adv_v);
      ch_ok_v    = ch_ok_v || (pend_ch_r == CH_W'(i));
      any_v      = any_v || (pend_r && (pend_ch_r == CH_W'(i)) && (sum_v[ACC_W] || !adv_v));
    end
    apply_any_s = pend_r && (any_v || !ch_ok_v);
  end

  // Channel accumulators, tick strobes, clock outputs and increment registers.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i] <= {ACC_W{1'b0}};
        inc_r[i] <= INIT_INC;
      end
      tick_r    <= {NUM_CH{1'b0}};
      clk_out_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!run_adv_s) begin
          acc_r[i]     <= {ACC_W{1'b0}};
          tick_r[i]    <= 1'b0;
          clk_out_r[i] <= 1'b0;
        end else if (ch_en[i]) begin
          acc_r[i]     <= sum_s[i][ACC_W-1:0];
          tick_r[i]    <= sum_s[i][ACC_W];
          clk_out_r[i] <= sum_s[i][ACC_W-1];
        end else begin
          tick_r[i]    <= 1'b0;
        end
        // The carrying add above still used the old increment.
        if (apply_s[i]) begin
          inc_r[i] <= pend_inc_r;
        end else begin
          inc_r[i] <= inc_r[i];
        end
      end
    end
  end

  // Single-entry update shadow; ready is low exactly while an update is held.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      pend_r      <= 1'b0;
      pend_ch_r   <= {CH_W{1'b0}};
      pend_inc_r  <= {ACC_W{1'b0}};
      cfg_ready_r <= 1'b1;
    end else if (pend_r) begin
      if (apply_any_s) begin
        pend_r      <= 1'b0;
        cfg_ready_r <= 1'b1;
      end else begin
        pend_r      <= 1'b1;
        cfg_ready_r <= 1'b0;
      end
    end else if (cfg_valid) begin
      pend_r      <= 1'b1;
      pend_ch_r   <= cfg_ch;
      pend_inc_r  <= cfg_inc;
      cfg_ready_r <= 1'b0;
    end else begin
      cfg_ready_r <= 1'b1;
    end
  end

  assign tick       = tick_r;
  assign clk_out    = clk_out_r;
  assign locked     = locked_r;
  assign relock_cnt = relock_r;
  assign cfg_ready  = cfg_ready_r;

endmodule

// File: tb/tb_camera_clkgen.sv
// Self-checking bench for camera_clkgen: table of per-increment tick/clk_out
// patterns plus directed sequences for lock timing, relock, saturation and
// runtime increment updates.
module tb_camera_clkgen;
  localparam int NUM_CH     = 3;
  localparam int ACC_W      = 24;
  localparam int SETTLE_CYC = 16;

  logic              clkin = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_lock = 1'b0;
  logic [NUM_CH-1:0] ch_en = 3'b000;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = 2'd0;
  logic [ACC_W-1:0]  cfg_inc = 24'h0;
  logic              sync_in = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic              locked;
  logic [7:0]        relock_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] inc;
    logic [7:0]  exp_tick;
    logic [7:0]  exp_clk;
  } vec_t;

  vec_t vecs [6];

  camera_clkgen #(
    .NUM_CH    (NUM_CH),
    .ACC_W     (ACC_W),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
`ifdef CLKGEN_SYNC_EN
    .sync      (sync_in),
`endif
    .tick      (tick),
    .clk_out   (clk_out),
    .locked    (locked),
    .relock_cnt(relock_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst_n = 1'b0;
    pll_lock = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [23:0] v);
    cfg_valid = 1'b1;
    cfg_ch = c;
    cfg_inc = v;
    @(negedge clkin);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_locked(input string name);
    int n = 0;
    while (locked !== 1'b1 && n < 64) begin
      @(negedge clkin);
      n++;
    end
    check(name, {31'd0, locked}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int to_cnt;
    int first_t;
    int first_c;
    logic [7:0] tp;
    logic [7:0] cp;

    vecs[0] = '{ch: 2'd0, inc: 24'h400000, exp_tick: 8'h88, exp_clk: 8'h66};
    vecs[1] = '{ch: 2'd0, inc: 24'h200000, exp_tick: 8'h80, exp_clk: 8'h78};
    vecs[2] = '{ch: 2'd0, inc: 24'h800000, exp_tick: 8'hAA, exp_clk: 8'h55};
    vecs[3] = '{ch: 2'd1, inc: 24'h000000, exp_tick: 8'h00, exp_clk: 8'h00};
    vecs[4] = '{ch: 2'd1, inc: 24'hFFFFFF, exp_tick: 8'hFE, exp_clk: 8'hFF};
    vecs[5] = '{ch: 2'd2, inc: 24'h300000, exp_tick: 8'h20, exp_clk: 8'h9C};

    // Reset state and lock timing: pll_lock from edge 5 -> locked after edge 21.
    @(negedge clkin);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_relock", {24'd0, relock_cnt}, 32'd0);
    check("rst_tick", {29'd0, tick}, 32'd0);
    check("rst_clk_out", {29'd0, clk_out}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      pll_lock = (e >= 5);
      @(negedge clkin);
      if (e == 20) check("lock_early", {31'd0, locked}, 32'd0);
      if (e == 21) check("lock_at_21", {31'd0, locked}, 32'd1);
    end
    check("lock_relock0", {24'd0, relock_cnt}, 32'd0);

    // Table of increments: 8-cycle tick and clk_out patterns after lock.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ch_en = 3'b111;
      cfg_write(vecs[i].ch, vecs[i].inc);
      check($sformatf("vec%0d_busy", i), {31'd0, cfg_ready}, 32'd0);
      @(negedge clkin);
      check($sformatf("vec%0d_ready", i), {31'd0, cfg_ready}, 32'd1);
      pll_lock = 1'b1;
      wait_locked($sformatf("vec%0d_lock", i));
      for (int k = 0; k < 8; k++) begin
        @(negedge clkin);
        tp[k] = tick[vecs[i].ch];
        cp[k] = clk_out[vecs[i].ch];
      end
      check($sformatf("vec%0d_tick", i), {24'd0, tp}, {24'd0, vecs[i].exp_tick});
      check($sformatf("vec%0d_clk", i), {24'd0, cp}, {24'd0, vecs[i].exp_clk});
    end

    // Reset increment 0x0A3D71: clk_out first high at k=13, first tick at k=25.
    do_reset();
    ch_en = 3'b001;
    pll_lock = 1'b1;
    wait_locked("init_lock");
    first_t = 0;
    first_c = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clkin);
      if (tick[0] && first_t == 0) first_t = k;
      if (clk_out[0] && first_c == 0) first_c = k;
    end
    check("init_first_tick", first_t, 32'd25);
    check("init_first_clk", first_c, 32'd13);

    // One-cycle lock drop in RUN, then relock after SETTLE_CYC.
    pll_lock = 1'b0;
    @(negedge clkin);
    check("drop_locked", {31'd0, locked}, 32'd0);
    check("drop_relock", {24'd0, relock_cnt}, 32'd1);
    check("drop_tick", {29'd0, tick}, 32'd0);
    check("drop_clk", {29'd0, clk_out}, 32'd0);
    pll_lock = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      @(negedge clkin);
      if (e == 16) check("relock_early", {31'd0, locked}, 32'd0);
      if (e == 17) check("relock_at_17", {31'd0, locked}, 32'd1);
    end

    // Saturation: 300 drops in total leave relock_cnt at 255.
    to_cnt = 0;
    for (int d = 2; d <= 300; d++) begin
      pll_lock = 1'b0;
      @(negedge clkin);
      pll_lock = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 64) begin
        @(negedge clkin);
        n++;
      end
      if (locked !== 1'b1) to_cnt++;
      if (d == 255) check("relock_255", {24'd0, relock_cnt}, 32'd255);
    end
    check("sat_timeouts", to_cnt, 32'd0);
    check("relock_sat", {24'd0, relock_cnt}, 32'd255);

    // Lock glitch during SETTLE: back to WAIT_LOCK, counter unchanged.
    do_reset();
    ch_en = 3'b000;
    for (int e = 1; e <= 23; e++) begin
      pll_lock = (e != 6);
      @(negedge clkin);
      if (e == 6)  check("glitch_relock", {24'd0, relock_cnt}, 32'd0);
      if (e == 22) check("glitch_early", {31'd0, locked}, 32'd0);
      if (e == 23) check("glitch_lock", {31'd0, locked}, 32'd1);
    end
    check("glitch_relock_end", {24'd0, relock_cnt}, 32'd0);

    // Runtime retune of ch1 0x400000 -> 0x200000 mid-period.
    do_reset();
    ch_en = 3'b010;
    cfg_write(2'd1, 24'h400000);
    @(negedge clkin);
    pll_lock = 1'b1;
    wait_locked("cfg_lock");
    n = 0;
    while (tick[1] !== 1'b1 && n < 16) begin
      @(negedge clkin);
      n++;
    end
    check("cfg_first_tick", {31'd0, tick[1]}, 32'd1);
    @(negedge clkin);
    cfg_write(2'd1, 24'h200000);
    check("cfg_busy0", {31'd0, cfg_ready}, 32'd0);
    @(negedge clkin);
    check("cfg_busy1", {31'd0, cfg_ready}, 32'd0);
    @(negedge clkin);
    check("cfg_old_wrap", {31'd0, tick[1]}, 32'd1);
    check("cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clkin);
      tp[k] = tick[1];
    end
    check("cfg_new_period", {24'd0, tp}, 32'h80);

    // Out-of-range channel: captured, discarded next edge, ch1 untouched.
    cfg_write(2'd3, 24'h000001);
    check("bad_busy", {31'd0, cfg_ready}, 32'd0);
    @(negedge clkin);
    check("bad_ready", {31'd0, cfg_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clkin);
      tp[k] = tick[1];
    end
    check("bad_period", {24'd0, tp}, 32'h20);

`ifdef CLKGEN_SYNC_EN
    // Sync pulse phase-aligns ch0 (period 4) and ch1 (period 8).
    do_reset();
    ch_en = 3'b011;
    cfg_write(2'd0, 24'h400000);
    @(negedge clkin);
    cfg_write(2'd1, 24'h200000);
    @(negedge clkin);
    pll_lock = 1'b1;
    wait_locked("sync_lock");
    for (int k = 0; k < 3; k++) @(negedge clkin);
    sync_in = 1'b1;
    @(negedge clkin);
    sync_in = 1'b0;
    check("sync_tick", {29'd0, tick}, 32'd0);
    check("sync_clk", {29'd0, clk_out}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clkin);
      tp[k] = tick[0];
      cp[k] = tick[1];
    end
    check("sync_ch0", {24'd0, tp}, 32'h88);
    check("sync_ch1", {24'd0, cp}, 32'h80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_clkgen.md
# camera_clkgen

Parametrised multi-channel clock-enable generator for the ISP camera/sensor clock domain, fed by a Gowin PLL output and its lock flag. Each channel runs a phase accumulator to produce a one-cycle `tick` strobe and an approximately 50 % `clk_out` at any rate f_clk·inc/2^ACC_W. A lock supervisor holds every channel idle until the PLL has been stably locked for a programmable settle time. Increments can be retuned at runtime through a valid/ready port without glitching.

## Interface
- `NUM_CH`, 2, number of output channels (1..8)
- `ACC_W`, 24, accumulator/increment width (8..32)
- `INIT_INC`, 24'h0A3D71, reset increment loaded into every channel
- `SETTLE_CYC`, 1024, cycles pll_lock must stay high before RUN (≥2)

- `clkin`  in  1  sole clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `pll_lock`  in  1  PLL lock flag, already synchronous to `clkin`
- `ch_en`  in  NUM_CH  per-channel run enable
- `cfg_valid`  in  1  increment update request
- `cfg_ready`  out  1  update port can accept
- `cfg_ch`  in  clog2(NUM_CH) (min 1)  target channel
- `cfg_inc`  in  ACC_W  new increment
- `tick`  out  NUM_CH  one-cycle strobe per accumulator wrap
- `clk_out`  out  NUM_CH  registered accumulator MSB
- `locked`  out  1  high in RUN
- `relock_cnt`  out  8  lock-loss event counter, saturating
- `sync`  in  1  present only with CLKGEN_SYNC_EN

## Operation
- Reset (rst_n=0 at an edge): state WAIT_LOCK; all acc=0, inc=INIT_INC, tick=0, clk_out=0, locked=0, relock_cnt=0, cfg_ready=1, no pending update.
- FSM:
  - WAIT_LOCK: pll_lock=1 → SETTLE, settle counter cleared.
  - SETTLE: counter increments each cycle; pll_lock=0 → WAIT_LOCK (no relock_cnt change); counter reaches SETTLE_CYC−1 with pll_lock=1 → RUN.
  - RUN: pll_lock=0 → WAIT_LOCK, relock_cnt+1 (saturates at 255).
- Outside RUN: acc held at 0, tick=0, clk_out=0; cfg port still operates.
- Channel i in RUN with ch_en[i]=1: {carry,acc} = acc + inc (ACC_W+1-bit sum); acc <= sum mod 2^ACC_W; tick[i] <= carry; clk_out[i] <= new acc MSB. ch_en[i]=0: acc held, tick=0, clk_out holds.
- inc=0: channel never ticks; clk_out constant.
- Config: cfg_valid & cfg_ready captures {cfg_ch,cfg_inc} into a single shadow, cfg_ready→0 next cycle. Pending update applies to inc of target channel on the first cycle in which that channel carries, or immediately (next edge) if channel is not advancing (ch_en=0, inc=0, or FSM not RUN). cfg_ready returns 1 the cycle after apply. cfg_ch ≥ NUM_CH: captured and discarded next cycle, no channel changes.
- Apply and carry in the same cycle: the carrying add uses old inc; new inc takes effect next cycle (glitch-free period boundary).

## Timing
- tick/clk_out registered: one cycle after the accumulating edge that wraps.
- RUN entered SETTLE_CYC cycles after first pll_lock=1 sample; locked rises same edge; first tick possible next cycle.
- pll_lock drop: locked=0, tick=0 the following edge; acc cleared same edge.
- Reset mid-operation overrides everything including pending update (dropped).

## Configuration
- `CLKGEN_SYNC_EN` defined: `sync` port exists; sync=1 in RUN clears all acc to 0 and forces tick=0, clk_out=0 next edge (phase-aligns channels); a pending update for a non-advancing channel still applies. Sync has priority over accumulate.
- Undefined: no `sync` port; channels align only via reset/relock.

## Test plan
- Reset, pll_lock=1 from cycle 5, SETTLE_CYC=16 → locked=1 at cycle 21; relock_cnt=0.
- RUN, ch0 inc=24'h400000, ch_en=1 → tick[0] every 4th cycle, clk_out[0] 2 high/2 low.
- pll_lock pulses low 1 cycle in RUN → locked=0 next edge, relock_cnt=1, relock after SETTLE_CYC; 300 drops → relock_cnt=255.
- cfg ch1 inc 24'h400000→24'h200000 mid-period → cfg_ready low until ch1 wrap; next period 8 cycles, no short period; cfg_ch=3 with NUM_CH=2 → ignored, ready back in 2 cycles.
- pll_lock glitches low during SETTLE → returns to WAIT_LOCK, relock_cnt unchanged.
- CLKGEN_SYNC_EN: ch0 inc 24'h400000, ch1 inc 24'h200000, sync pulse → both acc=0 next edge, ticks coincide every 8 cycles.
